// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: synchronizer, debounce FSM, registered press/release pulses and level.
// Optional long-hold pulse is built only when BTN_LONG_PRESS_EN is defined.
module btn_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_pulse_gen: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("btn_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("btn_pulse_gen: LONG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  state_t                 state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Any opposite sample inside a WAIT state drops back and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state <= WAIT_PRESS;
            cnt   <= CW'(1);
          end
        end
        WAIT_PRESS: begin
          if (!btn_sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state <= WAIT_RELEASE;
            cnt   <= CW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (btn_sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

  logic [LW-1:0] long_cnt;

  // Saturating hold counter; release bounces keep counting, only IDLE clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (state == IDLE) begin
        long_cnt <= '0;
      end else if ((state == PRESSED || state == WAIT_RELEASE) && long_cnt != LONG_MAX) begin
        long_cnt   <= long_cnt + 1'b1;
        long_pulse <= (long_cnt == (LONG_MAX - 1'b1));
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_btn_pulse_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;
  logic mode;
  int   checks = 0;
  int   failures = 0;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  btn_pulse_gen #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  // Stand-in for the display mode-toggle unit fed by press_pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) mode <= 1'b0;
    else if (press_pulse) mode <= ~mode;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_in = 1'b0;
    repeat (3) tick();
    checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL reset_level got=%b exp=0", btn_level); end
    checks++; if (press_pulse !== 1'b0) begin failures++; $display("FAIL reset_press got=%b exp=0", press_pulse); end
    checks++; if (release_pulse !== 1'b0) begin failures++; $display("FAIL reset_release got=%b exp=0", release_pulse); end
    checks++; if (long_pulse !== 1'b0) begin failures++; $display("FAIL reset_long got=%b exp=0", long_pulse); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=000", {btn_level, press_pulse, release_pulse});
    end
  endtask

  task automatic test_clean_press;
    btn_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (press_pulse !== (i == 7)) begin failures++; $display("FAIL press_pulse cyc=%0d got=%b exp=%b", i, press_pulse, (i == 7)); end
      checks++; if (btn_level !== (i >= 7)) begin failures++; $display("FAIL press_level cyc=%0d got=%b exp=%b", i, btn_level, (i >= 7)); end
      checks++; if (release_pulse !== 1'b0) begin failures++; $display("FAIL press_release cyc=%0d got=%b exp=0", i, release_pulse); end
      checks++; if (long_pulse !== 1'b0) begin failures++; $display("FAIL press_long cyc=%0d got=%b exp=0", i, long_pulse); end
    end
  endtask

  task automatic test_clean_release;
    btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (release_pulse !== (i == 7)) begin failures++; $display("FAIL release_pulse cyc=%0d got=%b exp=%b", i, release_pulse, (i == 7)); end
      checks++; if (btn_level !== (i < 7)) begin failures++; $display("FAIL release_level cyc=%0d got=%b exp=%b", i, btn_level, (i < 7)); end
      checks++; if (press_pulse !== 1'b0) begin failures++; $display("FAIL release_press cyc=%0d got=%b exp=0", i, press_pulse); end
    end
  endtask

  task automatic test_bounce;
    bit pat [16];
    pat = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      btn_in = pat[i];
      tick();
      checks++; if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
        failures++; $display("FAIL bounce cyc=%0d got=%b exp=000", i, {btn_level, press_pulse, release_pulse});
      end
    end
  endtask

  task automatic test_reset_mid;
    btn_in = 1'b1;
    repeat (5) tick();
    checks++; if ({btn_level, press_pulse} !== 2'b00) begin failures++; $display("FAIL mid_pre got=%b exp=00", {btn_level, press_pulse}); end
    rst = 1'b1;
    #1;
    checks++; if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
      failures++; $display("FAIL mid_async got=%b exp=000", {btn_level, press_pulse, release_pulse});
    end
    repeat (2) tick();
    checks++; if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
      failures++; $display("FAIL mid_held got=%b exp=000", {btn_level, press_pulse, release_pulse});
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (press_pulse !== (i == 7)) begin failures++; $display("FAIL mid_press cyc=%0d got=%b exp=%b", i, press_pulse, (i == 7)); end
      checks++; if (btn_level !== (i >= 7)) begin failures++; $display("FAIL mid_level cyc=%0d got=%b exp=%b", i, btn_level, (i >= 7)); end
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (release_pulse !== (i == 7)) begin failures++; $display("FAIL mid_release cyc=%0d got=%b exp=%b", i, release_pulse, (i == 7)); end
    end
  endtask

  task automatic test_long_press;
    int np = 0;
    int nl = 0;
    btn_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (press_pulse) np++;
      if (long_pulse) nl++;
      checks++; if (press_pulse !== (i == 7)) begin failures++; $display("FAIL long_press cyc=%0d got=%b exp=%b", i, press_pulse, (i == 7)); end
      checks++; if (long_pulse !== (LONG_EN && i == 27)) begin
        failures++; $display("FAIL long_pulse cyc=%0d got=%b exp=%b", i, long_pulse, (LONG_EN && i == 27));
      end
      checks++; if (press_pulse && release_pulse) begin failures++; $display("FAIL press_and_release cyc=%0d got=11 exp=not both", i); end
    end
    checks++; if (np !== 1) begin failures++; $display("FAIL long_press_count got=%0d exp=1", np); end
    checks++; if (nl !== (LONG_EN ? 1 : 0)) begin failures++; $display("FAIL long_pulse_count got=%0d exp=%0d", nl, (LONG_EN ? 1 : 0)); end
    btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (release_pulse !== (i == 7)) begin failures++; $display("FAIL long_release cyc=%0d got=%b exp=%b", i, release_pulse, (i == 7)); end
      checks++; if (long_pulse !== 1'b0) begin failures++; $display("FAIL long_after cyc=%0d got=%b exp=0", i, long_pulse); end
    end
  endtask

  task automatic test_downstream;
    rst = 1'b1;
    btn_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (mode !== 1'b0) begin failures++; $display("FAIL mode_init got=%b exp=0", mode); end
    btn_in = 1'b1; repeat (10) tick();
    btn_in = 1'b0; repeat (10) tick();
    checks++; if (mode !== 1'b1) begin failures++; $display("FAIL mode_first got=%b exp=1", mode); end
    btn_in = 1'b1; repeat (10) tick();
    btn_in = 1'b0; repeat (10) tick();
    checks++; if (mode !== 1'b0) begin failures++; $display("FAIL mode_second got=%b exp=0", mode); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_reset_mid();
    test_long_press();
    test_downstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
